// File: rtl/sub16_sched.sv
// Round-robin scheduler sharing one 4-bit borrow-ripple subtractor slice between two
// requesters; computes A - B - bin one nibble per clock, LSB first.
module sub16_sched #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req,
  input  logic [4*NIBBLES-1:0]   a0,
  input  logic [4*NIBBLES-1:0]   b0,
  input  logic                   bin0,
  input  logic [4*NIBBLES-1:0]   a1,
  input  logic [4*NIBBLES-1:0]   b1,
  input  logic                   bin1,
  output logic [1:0]             gnt,
  output logic                   busy,
  output logic                   done,
  output logic                   id,
  output logic [4*NIBBLES-1:0]   diff,
  output logic                   bout,
  output logic                   zero,
  output logic                   ovf
);

  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [KW-1:0] k, k_nxt;
  logic          ptr, ptr_nxt;
  logic [W-1:0]  a_q, a_nxt;
  logic [W-1:0]  b_q, b_nxt;
  logic          bin_q, bin_nxt;
  logic          brw_q, brw_nxt;
  logic [W-1:0]  acc_q, acc_nxt;

  logic [1:0]    gnt_nxt;
  logic          busy_nxt;
  logic          done_nxt;
  logic          id_nxt;
  logic [W-1:0]  diff_nxt;
  logic          bout_nxt;
  logic          zero_nxt;
  logic          ovf_nxt;

  logic          win;
  logic [KW+1:0] nib_lo;
  logic [3:0]    slice_a;
  logic [3:0]    slice_b;
  logic          slice_cin;
  logic [4:0]    slice_out;

  // Shared nibble slice: returns {borrow_out, difference[3:0]}.
  function automatic logic [4:0] sub_slice(input logic [3:0] x, input logic [3:0] y,
                                           input logic c);
    logic [3:0] s;
    logic       br;
    br = c;
    for (int i = 0; i < 4; i++) begin
      s[i] = x[i] ^ y[i] ^ br;
      br   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br);
    end
    return {br, s};
  endfunction

  // Pointer side wins a tie; a lone request always wins.
  assign win       = req[1] & (~req[0] | ptr);
  assign nib_lo    = {k, 2'b00};
  assign slice_a   = a_q[nib_lo +: 4];
  assign slice_b   = b_q[nib_lo +: 4];
  assign slice_cin = (k == '0) ? bin_q : brw_q;
  assign slice_out = sub_slice(slice_a, slice_b, slice_cin);

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    ptr_nxt   = ptr;
    a_nxt     = a_q;
    b_nxt     = b_q;
    bin_nxt   = bin_q;
    brw_nxt   = brw_q;
    acc_nxt   = acc_q;
    gnt_nxt   = 2'b00;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    id_nxt    = id;
    diff_nxt  = diff;
    bout_nxt  = bout;
    zero_nxt  = zero;
    ovf_nxt   = ovf;

    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (req != 2'b00) begin
          state_nxt    = RUN;
          k_nxt        = '0;
          ptr_nxt      = ~win;
          a_nxt        = win ? a1 : a0;
          b_nxt        = win ? b1 : b0;
          bin_nxt      = win ? bin1 : bin0;
          brw_nxt      = 1'b0;
          acc_nxt      = '0;
          gnt_nxt[win] = 1'b1;
          busy_nxt     = 1'b1;
          id_nxt       = win;
        end
      end

      RUN: begin
        acc_nxt[nib_lo +: 4] = slice_out[3:0];
        brw_nxt              = slice_out[4];
        k_nxt                = k + 1'b1;
        // Results are published only on the final nibble so outputs stay stable between dones.
        if (k == K_LAST) begin
          state_nxt = DONE;
          k_nxt     = '0;
          done_nxt  = 1'b1;
          diff_nxt  = acc_nxt;
          bout_nxt  = slice_out[4];
          zero_nxt  = (acc_nxt == '0);
          ovf_nxt   = (a_q[W-1] != b_q[W-1]) && (acc_nxt[W-1] != a_q[W-1]);
        end
      end

      DONE: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end

      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      k     <= '0;
      ptr   <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      bin_q <= 1'b0;
      brw_q <= 1'b0;
      acc_q <= '0;
      gnt   <= 2'b00;
      busy  <= 1'b0;
      done  <= 1'b0;
      id    <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      zero  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      ptr   <= ptr_nxt;
      a_q   <= a_nxt;
      b_q   <= b_nxt;
      bin_q <= bin_nxt;
      brw_q <= brw_nxt;
      acc_q <= acc_nxt;
      gnt   <= gnt_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      id    <= id_nxt;
      diff  <= diff_nxt;
      bout  <= bout_nxt;
      zero  <= zero_nxt;
      ovf   <= ovf_nxt;
    end
  end

endmodule
